// File: rtl/rupt_ctrl.sv
// rupt_ctrl -- AGC pipeline interrupt (RUPT) controller.
//
// Latches per-source interrupt requests and arbitrates them by fixed
// priority (bit 0 highest). At a legal instruction boundary, with
// interrupts neither inhibited nor blocked by accumulator overflow, it
// takes the winner:
//   - pulses rupt_take/flush for one cycle;
//   - presents the vector address, the return PC and the source index;
//   - holds in_rupt until RESUME retires.
// No nested interrupts are taken while in_rupt is high.
//
// Ports:
//   clock      in   rising-edge clock
//   rst_l      in   synchronous active-low reset
//   rupt_req   in   [NUM_RUPT] per-source request (sets pending bit)
//   inhint     in   INHINT retired pulse (sets inhibit)
//   relint     in   RELINT retired pulse (clears inhibit)
//   resume     in   RESUME retired pulse (leaves ISR)
//   boundary   in   decode is at a legal interrupt boundary
//   a_ovf      in   accumulator overflow, blocks interrupts
//   pc_D       in   [12] PC of the instruction in decode
//   rupt_take  out  interrupt entry pulse
//   flush      out  fetch/decode flush pulse, same cycle as rupt_take
//   vector     out  [12] redirect address
//   save_pc    out  [12] return address for ZRUPT
//   rupt_id    out  [4] taken source index
//   in_rupt    out  ISR active
//   pending    out  [NUM_RUPT] latched requests
//   inhibit    out  global inhibit flag
//   rupt_lock  out  watchdog alarm
//
// Build option: define RUPT_WATCHDOG_EN to build the ISR watchdog
// counter; otherwise rupt_lock is tied low.

module rupt_ctrl #(
    parameter int unsigned NUM_RUPT      = 10,
    parameter int unsigned VECTOR_BASE   = 'o4000,
    parameter int unsigned VECTOR_STRIDE = 4,
    parameter int unsigned RUPT_TIMEOUT  = 'd4096
) (
    input  logic                clock,
    input  logic                rst_l,
    input  logic [NUM_RUPT-1:0] rupt_req,
    input  logic                inhint,
    input  logic                relint,
    input  logic                resume,
    input  logic                boundary,
    input  logic                a_ovf,
    input  logic [11:0]         pc_D,
    output logic                rupt_take,
    output logic                flush,
    output logic [11:0]         vector,
    output logic [11:0]         save_pc,
    output logic [3:0]          rupt_id,
    output logic                in_rupt,
    output logic [NUM_RUPT-1:0] pending,
    output logic                inhibit,
    output logic                rupt_lock
);

    // rupt_id is 4 bits wide, so at most 16 sources can be encoded.
    if (NUM_RUPT < 1 || NUM_RUPT > 16 || RUPT_TIMEOUT < 1) begin : g_param_check
        $error("rupt_ctrl: NUM_RUPT must be 1..16 and RUPT_TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        ISR
    } state_t;

    state_t              state;
    logic                go;
    logic [3:0]          winner;
    logic [NUM_RUPT-1:0] clr_mask;
    logic [11:0]         vec_next;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i < NUM_RUPT; i++) begin
            if (pending[NUM_RUPT-1-i]) begin
                winner = 4'(NUM_RUPT - 1 - i);
            end
        end
    end

    assign go = (state == IDLE) && (|pending) && !inhibit && !a_ovf && boundary;

    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < NUM_RUPT; i++) begin
            clr_mask[i] = go && (32'(winner) == i);
        end
    end

    assign vec_next = 12'(VECTOR_BASE + VECTOR_STRIDE * (32'(winner) + 32'd1));

    always_ff @(posedge clock) begin
        if (!rst_l) begin
            state     <= IDLE;
            pending   <= '0;
            inhibit   <= 1'b0;
            in_rupt   <= 1'b0;
            rupt_take <= 1'b0;
            flush     <= 1'b0;
            vector    <= '0;
            save_pc   <= '0;
            rupt_id   <= '0;
        end else begin
            // Clear wins over a same-edge set: that request merges with
            // the one now being serviced.
            pending <= (pending | rupt_req) & ~clr_mask;

            if (inhint) begin
                inhibit <= 1'b1;
            end else if (relint) begin
                inhibit <= 1'b0;
            end

            rupt_take <= 1'b0;
            flush     <= 1'b0;

            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= TAKE;
                        rupt_take <= 1'b1;
                        flush     <= 1'b1;
                        rupt_id   <= winner;
                        vector    <= vec_next;
                        save_pc   <= pc_D;
                    end
                end
                TAKE: begin
                    state   <= ISR;
                    in_rupt <= 1'b1;
                end
                ISR: begin
                    if (resume) begin
                        state   <= IDLE;
                        in_rupt <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    in_rupt <= 1'b0;
                end
            endcase
        end
    end

`ifdef RUPT_WATCHDOG_EN
    localparam int unsigned CW = $clog2(RUPT_TIMEOUT + 1);

    logic [CW-1:0] wd_count;
    logic [CW-1:0] wd_inc;

    assign wd_inc = wd_count + 1'b1;

    always_ff @(posedge clock) begin
        if (!rst_l) begin
            wd_count  <= '0;
            rupt_lock <= 1'b0;
        end else if (go) begin
            wd_count <= '0;
        end else if (state == ISR) begin
            if (resume) begin
                rupt_lock <= 1'b0;
            end else if (wd_count < CW'(RUPT_TIMEOUT)) begin
                wd_count <= wd_inc;
                if (wd_inc == CW'(RUPT_TIMEOUT)) begin
                    rupt_lock <= 1'b1;
                end
            end
        end
    end
`else
    assign rupt_lock = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_ctrl.sv
// tb_rupt_ctrl -- directed self-checking bench for rupt_ctrl (default build).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, i.e. they show what the preceding edge stored.

module tb_rupt_ctrl;

    localparam int unsigned N = 10;

    logic          clock;
    logic          rst_l;
    logic [N-1:0]  rupt_req;
    logic          inhint;
    logic          relint;
    logic          resume;
    logic          boundary;
    logic          a_ovf;
    logic [11:0]   pc_D;
    logic          rupt_take;
    logic          flush;
    logic [11:0]   vector;
    logic [11:0]   save_pc;
    logic [3:0]    rupt_id;
    logic          in_rupt;
    logic [N-1:0]  pending;
    logic          inhibit;
    logic          rupt_lock;

    int passed;
    int total;

    rupt_ctrl #(
        .NUM_RUPT      (N),
        .VECTOR_BASE   ('o4000),
        .VECTOR_STRIDE (4),
        .RUPT_TIMEOUT  (8)
    ) dut (
        .clock     (clock),
        .rst_l     (rst_l),
        .rupt_req  (rupt_req),
        .inhint    (inhint),
        .relint    (relint),
        .resume    (resume),
        .boundary  (boundary),
        .a_ovf     (a_ovf),
        .pc_D      (pc_D),
        .rupt_take (rupt_take),
        .flush     (flush),
        .vector    (vector),
        .save_pc   (save_pc),
        .rupt_id   (rupt_id),
        .in_rupt   (in_rupt),
        .pending   (pending),
        .inhibit   (inhibit),
        .rupt_lock (rupt_lock)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Finish an ISR cleanly: resume pulse, then one idle cycle.
    task automatic finish_isr();
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        step();
        step();
        total++; if (rupt_take !== 1'b0) $display("FAIL reset_take got=%b exp=0", rupt_take); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush got=%b exp=0", flush); else passed++;
        total++; if (in_rupt !== 1'b0) $display("FAIL reset_in_rupt got=%b exp=0", in_rupt); else passed++;
        total++; if (pending !== 10'b0) $display("FAIL reset_pending got=%b exp=0", pending); else passed++;
        total++; if (inhibit !== 1'b0) $display("FAIL reset_inhibit got=%b exp=0", inhibit); else passed++;
        total++; if (rupt_lock !== 1'b0) $display("FAIL reset_lock got=%b exp=0", rupt_lock); else passed++;
        total++; if ({vector, save_pc, rupt_id} !== 28'h0) $display("FAIL reset_regs got=%h/%h/%h exp=0/0/0", vector, save_pc, rupt_id); else passed++;
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_single();
        boundary = 1'b1;
        pc_D = 12'o1234;
        rupt_req = 10'b0000000100;  // cycle n
        step();                      // cycle n+1
        rupt_req = '0;
        pc_D = 12'o0567;
        total++; if (pending !== 10'b0000000100) $display("FAIL single_pending got=%b exp=0000000100", pending); else passed++;
        total++; if (rupt_take !== 1'b0) $display("FAIL single_early_take got=%b exp=0", rupt_take); else passed++;
        step();                      // cycle n+2
        pc_D = 12'o7777;
        total++; if (rupt_take !== 1'b1) $display("FAIL single_take got=%b exp=1", rupt_take); else passed++;
        total++; if (flush !== 1'b1) $display("FAIL single_flush got=%b exp=1", flush); else passed++;
        total++; if (vector !== 12'o4014) $display("FAIL single_vector got=%o exp=4014", vector); else passed++;
        total++; if (rupt_id !== 4'd2) $display("FAIL single_id got=%0d exp=2", rupt_id); else passed++;
        total++; if (save_pc !== 12'o0567) $display("FAIL single_save_pc got=%o exp=0567", save_pc); else passed++;
        total++; if (pending !== 10'b0) $display("FAIL single_pending_clr got=%b exp=0", pending); else passed++;
        total++; if (in_rupt !== 1'b0) $display("FAIL single_in_rupt_take got=%b exp=0", in_rupt); else passed++;
        step();                      // cycle n+3
        total++; if (in_rupt !== 1'b1) $display("FAIL single_in_rupt got=%b exp=1", in_rupt); else passed++;
        total++; if (rupt_take !== 1'b0) $display("FAIL single_take_pulse got=%b exp=0", rupt_take); else passed++;
        total++; if (save_pc !== 12'o0567) $display("FAIL single_save_hold got=%o exp=0567", save_pc); else passed++;
        resume = 1'b1;
        step();
        resume = 1'b0;
        total++; if (in_rupt !== 1'b0) $display("FAIL single_resume got=%b exp=0", in_rupt); else passed++;
        step();
    endtask

    task automatic test_priority();
        rupt_req = 10'b0000001010;
        step();
        rupt_req = '0;
        total++; if (pending !== 10'b0000001010) $display("FAIL prio_pending got=%b exp=0000001010", pending); else passed++;
        step();
        total++; if (rupt_take !== 1'b1 || rupt_id !== 4'd1) $display("FAIL prio_first got=%b/%0d exp=1/1", rupt_take, rupt_id); else passed++;
        total++; if (vector !== 12'o4010) $display("FAIL prio_vector1 got=%o exp=4010", vector); else passed++;
        total++; if (pending !== 10'b0000001000) $display("FAIL prio_loser got=%b exp=0000001000", pending); else passed++;
        // Request arriving mid-ISR must latch but not be taken.
        rupt_req = 10'b0000100000;
        step();
        rupt_req = '0;
        for (int i = 0; i < 4; i++) step();
        total++; if (in_rupt !== 1'b1 || rupt_take !== 1'b0) $display("FAIL prio_no_nest got=%b/%b exp=1/0", in_rupt, rupt_take); else passed++;
        total++; if (pending !== 10'b0000101000) $display("FAIL prio_isr_pending got=%b exp=0000101000", pending); else passed++;
        resume = 1'b1;               // cycle m
        step();                      // m+1
        resume = 1'b0;
        total++; if (in_rupt !== 1'b0 || rupt_take !== 1'b0) $display("FAIL prio_m1 got=%b/%b exp=0/0", in_rupt, rupt_take); else passed++;
        step();                      // m+2
        total++; if (rupt_take !== 1'b1 || rupt_id !== 4'd3) $display("FAIL prio_second got=%b/%0d exp=1/3", rupt_take, rupt_id); else passed++;
        total++; if (vector !== 12'o4020) $display("FAIL prio_vector2 got=%o exp=4020", vector); else passed++;
        total++; if (pending !== 10'b0000100000) $display("FAIL prio_pending2 got=%b exp=0000100000", pending); else passed++;
        step();
        finish_isr();
        // Source 5 remains and is taken right after that resume.
        total++; if (rupt_take !== 1'b1 || rupt_id !== 4'd5) $display("FAIL prio_third got=%b/%0d exp=1/5", rupt_take, rupt_id); else passed++;
        total++; if (vector !== 12'o4030) $display("FAIL prio_vector3 got=%o exp=4030", vector); else passed++;
        step();
        finish_isr();
    endtask

    task automatic test_inhibit();
        int bad;
        inhint = 1'b1;
        step();
        inhint = 1'b0;
        total++; if (inhibit !== 1'b1) $display("FAIL inh_set got=%b exp=1", inhibit); else passed++;
        rupt_req = 10'b0000000001;
        step();
        rupt_req = '0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rupt_take !== 1'b0 || pending[0] !== 1'b1) bad++;
            step();
        end
        total++; if (bad != 0) $display("FAIL inh_blocked got=%0d bad_cycles exp=0", bad); else passed++;
        relint = 1'b1;               // cycle k
        step();                      // k+1
        relint = 1'b0;
        total++; if (inhibit !== 1'b0 || rupt_take !== 1'b0) $display("FAIL inh_k1 got=%b/%b exp=0/0", inhibit, rupt_take); else passed++;
        step();                      // k+2
        total++; if (rupt_take !== 1'b1 || rupt_id !== 4'd0) $display("FAIL inh_take got=%b/%0d exp=1/0", rupt_take, rupt_id); else passed++;
        total++; if (vector !== 12'o4004) $display("FAIL inh_vector got=%o exp=4004", vector); else passed++;
        step();
        finish_isr();
        inhint = 1'b1;
        relint = 1'b1;
        step();
        inhint = 1'b0;
        relint = 1'b0;
        total++; if (inhibit !== 1'b1) $display("FAIL inh_both got=%b exp=1", inhibit); else passed++;
        relint = 1'b1;
        step();
        relint = 1'b0;
        total++; if (inhibit !== 1'b0) $display("FAIL inh_release got=%b exp=0", inhibit); else passed++;
    endtask

    task automatic test_blocking();
        int bad;
        // Boundary held low.
        boundary = 1'b0;
        rupt_req = 10'b0000010000;
        step();
        rupt_req = '0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rupt_take !== 1'b0 || pending[4] !== 1'b1) bad++;
            step();
        end
        total++; if (bad != 0) $display("FAIL blk_boundary got=%0d bad_cycles exp=0", bad); else passed++;
        boundary = 1'b1;
        step();
        total++; if (rupt_take !== 1'b1 || rupt_id !== 4'd4) $display("FAIL blk_boundary_take got=%b/%0d exp=1/4", rupt_take, rupt_id); else passed++;
        total++; if (vector !== 12'o4024) $display("FAIL blk_vector got=%o exp=4024", vector); else passed++;
        step();
        finish_isr();
        // Accumulator overflow held high.
        a_ovf = 1'b1;
        rupt_req = 10'b0000010000;
        step();
        rupt_req = '0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rupt_take !== 1'b0 || pending[4] !== 1'b1) bad++;
            step();
        end
        total++; if (bad != 0) $display("FAIL blk_ovf got=%0d bad_cycles exp=0", bad); else passed++;
        a_ovf = 1'b0;
        step();
        total++; if (rupt_take !== 1'b1 || rupt_id !== 4'd4) $display("FAIL blk_ovf_take got=%b/%0d exp=1/4", rupt_take, rupt_id); else passed++;
        step();
        finish_isr();
    endtask

    task automatic test_reset_mid();
        pc_D = 12'o3333;
        rupt_req = 10'b0001000000;
        step();
        rupt_req = '0;
        step();
        total++; if (rupt_take !== 1'b1) $display("FAIL rst_pre_take got=%b exp=1", rupt_take); else passed++;
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        total++; if (rupt_take !== 1'b0 || flush !== 1'b0 || in_rupt !== 1'b0) $display("FAIL rst_mid_ctl got=%b/%b/%b exp=0/0/0", rupt_take, flush, in_rupt); else passed++;
        total++; if ({vector, save_pc, rupt_id} !== 28'h0) $display("FAIL rst_mid_regs got=%h/%h/%h exp=0/0/0", vector, save_pc, rupt_id); else passed++;
        total++; if (pending !== 10'b0 || inhibit !== 1'b0) $display("FAIL rst_mid_flags got=%b/%b exp=0/0", pending, inhibit); else passed++;
        step();
        total++; if (in_rupt !== 1'b0 || rupt_take !== 1'b0) $display("FAIL rst_abandon got=%b/%b exp=0/0", in_rupt, rupt_take); else passed++;
        // Stray resume in IDLE.
        resume = 1'b1;
        step();
        resume = 1'b0;
        total++; if (in_rupt !== 1'b0 || rupt_take !== 1'b0) $display("FAIL stray_idle got=%b/%b exp=0/0", in_rupt, rupt_take); else passed++;
        // Resume during TAKE is ignored: ISR still entered.
        rupt_req = 10'b0010000000;
        step();
        rupt_req = '0;
        step();
        resume = 1'b1;
        step();
        resume = 1'b0;
        total++; if (in_rupt !== 1'b1) $display("FAIL stray_take got=%b exp=1", in_rupt); else passed++;
        total++; if (rupt_lock !== 1'b0) $display("FAIL lock_default got=%b exp=0", rupt_lock); else passed++;
        finish_isr();
        total++; if (in_rupt !== 1'b0) $display("FAIL stray_exit got=%b exp=0", in_rupt); else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst_l    = 1'b0;
        rupt_req = '0;
        inhint   = 1'b0;
        relint   = 1'b0;
        resume   = 1'b0;
        boundary = 1'b0;
        a_ovf    = 1'b0;
        pc_D     = '0;
        test_reset();
        test_single();
        test_priority();
        test_inhibit();
        test_blocking();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
